// File: rtl/cpu_axi_pkg.sv
// Shared definitions for the SRAM-like side of the CPU AXI path:
// transfer-size encodings and the bridge FSM state type.
package cpu_axi_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/sram_to_sram_like_bridge_wen_to_size_addr.sv
// Byte-enable to transfer size / low address decoder for 32-bit stores.
// An all-zero enable is a word load; unsupported patterns are flagged as not legal.
module wen_to_size_addr
    import cpu_axi_pkg::*;
(
    input  logic [3:0] wen,
    output logic [1:0] size,
    output logic [1:0] offset,
    output logic       wr,
    output logic       legal
);

    always_comb begin
        size   = SIZE_WORD;
        offset = 2'b00;
        wr     = 1'b1;
        legal  = 1'b0;
        case (wen)
            4'b0001: begin size = SIZE_BYTE; offset = 2'b00; legal = 1'b1; end
            4'b0010: begin size = SIZE_BYTE; offset = 2'b01; legal = 1'b1; end
            4'b0100: begin size = SIZE_BYTE; offset = 2'b10; legal = 1'b1; end
            4'b1000: begin size = SIZE_BYTE; offset = 2'b11; legal = 1'b1; end
            4'b0011: begin size = SIZE_HALF; offset = 2'b00; legal = 1'b1; end
            4'b1100: begin size = SIZE_HALF; offset = 2'b10; legal = 1'b1; end
            4'b1111: begin size = SIZE_WORD; offset = 2'b00; legal = 1'b1; end
            4'b0000: begin wr = 1'b0; legal = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/sram_to_sram_like_bridge.sv
// Converts a one-cycle SRAM-style pipeline access into one SRAM-like
// req/addr_ok/data_ok transaction, stalling the pipeline until it completes.
module sram_to_sram_like_bridge
    import cpu_axi_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter bit WRITE_EN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sram_en,
    input  logic [DATA_W/8-1:0]   sram_wen,
    input  logic [ADDR_W-1:0]     sram_addr,
    input  logic [DATA_W-1:0]     sram_wdata,
    output logic [DATA_W-1:0]     sram_rdata,
    output logic                  stall,
    input  logic                  longest_stall,
    output logic                  req,
    output logic                  wr,
    output logic [1:0]            size,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     wdata,
    input  logic                  addr_ok,
    input  logic                  data_ok,
    input  logic [DATA_W-1:0]     rdata
);

    if (DATA_W != 32) begin : g_width_check
        $error("sram_to_sram_like_bridge supports DATA_W = 32 only");
    end

    bridge_state_t     state_reg;
    logic              wr_lat_reg;
    logic              en_lat_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic [1:0] dec_size;
    logic [1:0] dec_offset;
    logic       dec_wr;
    logic       dec_legal;
    logic       req_wr;

    wen_to_size_addr u_wen_dec (
        .wen    (sram_wen[3:0]),
        .size   (dec_size),
        .offset (dec_offset),
        .wr     (dec_wr),
        .legal  (dec_legal)
    );

    // Request attributes follow the pipeline inputs directly; they only matter while req is high.
    assign req_wr = WRITE_EN ? dec_wr : 1'b0;
    assign wr     = req_wr;
    assign size   = WRITE_EN ? dec_size : SIZE_WORD;
    assign addr   = WRITE_EN ? {sram_addr[ADDR_W-1:2], dec_offset} : sram_addr;
    assign wdata  = WRITE_EN ? sram_wdata : '0;

    // Gated by rst_n so both handshake outputs drop the moment reset is asserted.
    assign req        = rst_n & sram_en & (state_reg == IDLE);
    assign stall      = rst_n & sram_en & (state_reg != DONE);
    assign sram_rdata = rdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            wr_lat_reg <= 1'b0;
            en_lat_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            if (WRITE_EN && sram_en && state_reg == IDLE) begin
                assert (dec_legal)
                    else $error("unsupported byte-enable pattern %b", sram_wen);
            end
            if (data_ok) begin
                assert (state_reg == WAIT || (state_reg == IDLE && sram_en && addr_ok))
                    else $error("data_ok with no outstanding transaction");
            end

            case (state_reg)
                IDLE: begin
                    if (sram_en && addr_ok) begin
                        wr_lat_reg <= req_wr;
                        en_lat_reg <= sram_en;
                        if (data_ok) begin
                            state_reg <= DONE;
                            if (!req_wr) begin
                                rdata_reg <= rdata;
                            end
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // The outstanding transaction must drain even if the pipeline gave up on it.
                    if (data_ok) begin
                        if (!wr_lat_reg) begin
                            rdata_reg <= rdata;
                        end
                        state_reg <= (sram_en && en_lat_reg) ? DONE : IDLE;
                    end
                end
                DONE: begin
                    if (!longest_stall) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
